// File: rtl/and_mult_serial_array.sv
// Bit-serial AND-multiplier array. Each lane multiplies a latched
// activation by a weight streamed one bit per accepted cycle, MSB first,
// using shift-and-add. All lanes share one FSM and one bit counter, so
// every lane finishes on the same cycle.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; accumulators keep their last value
// RUN   | accepting weight bits on bit_valid, one shift-add per bit
// DONE  | product complete, out_valid high until out_ready handshake
module and_mult_serial_array #(
    parameter int LANES    = 32,
    parameter int ACT_W    = 16,
    parameter int WGT_BITS = 8,
    parameter int SIGNED_W = 0,
    localparam int ACC_W   = ACT_W + WGT_BITS,
    localparam int CNT_W   = $clog2(WGT_BITS + 1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LANES*ACT_W-1:0]   activation,
    input  logic [LANES-1:0]         weight_bit,
    input  logic                     bit_valid,
    input  logic                     clear,
    output logic                     busy,
    output logic [CNT_W-1:0]         bit_count,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*ACC_W-1:0]   result
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WGT_BITS - 1);

    state_t           state;
    logic [CNT_W-1:0] bit_cnt;

    // Shared control: one counter and one FSM drive every lane.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            bit_cnt   <= '0;
        end else if (clear) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state   <= ST_RUN;
                        busy    <= 1'b1;
                        bit_cnt <= '0;
                    end
                end
                ST_RUN: begin
                    if (bit_valid) begin
                        bit_cnt <= bit_cnt + 1'b1;
                        // The last bit's edge enters DONE, so out_valid is
                        // visible one cycle after the last bit was presented.
                        if (bit_cnt == LAST_CNT) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                    bit_cnt   <= '0;
                end
            endcase
        end
    end

    assign bit_count = bit_cnt;

    wire load_act = (state == ST_IDLE) && start;
    wire step_acc = (state == ST_RUN) && bit_valid;
    // In signed mode the MSB carries negative weight, so it is subtracted.
    wire msb_neg  = (SIGNED_W != 0) && (bit_cnt == '0);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [ACT_W-1:0] act_q;
        logic [ACC_W-1:0] acc_q;
        logic [ACC_W-1:0] addend;
        logic [ACC_W-1:0] shifted;
        logic [ACC_W-1:0] acc_next;

        // Shift-and-add (or subtract on a signed MSB), truncated to ACC_W.
        always_comb begin
            addend   = weight_bit[i] ? ACC_W'(act_q) : '0;
            shifted  = acc_q << 1;
            acc_next = msb_neg ? (shifted - addend) : (shifted + addend);
        end

        // Per-lane activation latch and accumulator.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_q <= '0;
                acc_q <= '0;
            end else if (clear) begin
                acc_q <= '0;
            end else if (load_act) begin
                act_q <= activation[i*ACT_W +: ACT_W];
                acc_q <= '0;
            end else if (step_acc) begin
                acc_q <= acc_next;
            end
        end

        assign result[i*ACC_W +: ACC_W] = acc_q;
    end

endmodule

// File: tb/tb_and_mult_serial_array.sv
// Bench for and_mult_serial_array: an unsigned and a signed instance share
// the same stimulus; a behavioural model predicts every output each cycle.
module tb_and_mult_serial_array;

    localparam int LANES = 32;
    localparam int ACT_W = 16;
    localparam int WB    = 8;
    localparam int ACC_W = ACT_W + WB;
    localparam int CW    = $clog2(WB + 1);
    localparam int RW    = LANES * ACC_W;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   clear = 1'b0;
    logic                   bit_valid = 1'b0;
    logic                   out_ready = 1'b0;
    logic [LANES*ACT_W-1:0] activation = '0;
    logic [LANES-1:0]       weight_bit = '0;

    logic            busy_u, ov_u, busy_s, ov_s;
    logic [CW-1:0]   bc_u, bc_s;
    logic [RW-1:0]   res_u, res_s;

    and_mult_serial_array #(.LANES(LANES), .ACT_W(ACT_W), .WGT_BITS(WB), .SIGNED_W(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .activation(activation),
        .weight_bit(weight_bit), .bit_valid(bit_valid), .clear(clear),
        .busy(busy_u), .bit_count(bc_u), .out_valid(ov_u),
        .out_ready(out_ready), .result(res_u));

    and_mult_serial_array #(.LANES(LANES), .ACT_W(ACT_W), .WGT_BITS(WB), .SIGNED_W(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .activation(activation),
        .weight_bit(weight_bit), .bit_valid(bit_valid), .clear(clear),
        .busy(busy_s), .bit_count(bc_s), .out_valid(ov_s),
        .out_ready(out_ready), .result(res_s));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
        end
    endtask

    // Model: phase 0=idle 1=run 2=done; m_wp holds the weight bits seen so
    // far as an integer, so the accumulator is act * (prefix of the weight).
    int     m_phase;
    int     m_k;
    longint m_act [LANES];
    longint m_wp  [LANES];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_k     <= 0;
            for (int i = 0; i < LANES; i++) begin
                m_act[i] <= 0;
                m_wp[i]  <= 0;
            end
        end else if (clear) begin
            m_phase <= 0;
            m_k     <= 0;
            for (int i = 0; i < LANES; i++) m_wp[i] <= 0;
        end else if (m_phase == 0) begin
            if (start) begin
                m_phase <= 1;
                m_k     <= 0;
                for (int i = 0; i < LANES; i++) begin
                    m_act[i] <= longint'(activation[i*ACT_W +: ACT_W]);
                    m_wp[i]  <= 0;
                end
            end
        end else if (m_phase == 1) begin
            if (bit_valid) begin
                m_k <= m_k + 1;
                for (int i = 0; i < LANES; i++) m_wp[i] <= m_wp[i] * 2 + longint'(weight_bit[i]);
                if (m_k == WB - 1) m_phase <= 2;
            end
        end else begin
            if (out_ready) m_phase <= 0;
        end
    end

    function automatic longint wval(input longint wp, input int k, input bit sgn);
        if (sgn && k > 0 && ((wp >> (k - 1)) & 1) != 0) return wp - (longint'(1) << k);
        return wp;
    endfunction

    function automatic logic [RW-1:0] model_res(input bit sgn);
        logic [RW-1:0] r;
        longint p;
        r = '0;
        for (int i = 0; i < LANES; i++) begin
            p = m_act[i] * wval(m_wp[i], m_k, sgn);
            r[i*ACC_W +: ACC_W] = p[ACC_W-1:0];
        end
        return r;
    endfunction

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        check("busy_u", RW'(busy_u), RW'(m_phase != 0));
        check("busy_s", RW'(busy_s), RW'(m_phase != 0));
        check("ov_u",   RW'(ov_u),   RW'(m_phase == 2));
        check("ov_s",   RW'(ov_s),   RW'(m_phase == 2));
        check("bc_u",   RW'(bc_u),   RW'(m_k));
        check("bc_s",   RW'(bc_s),   RW'(m_k));
        check("res_u",  res_u,       model_res(1'b0));
        check("res_s",  res_s,       model_res(1'b1));
    end

    int act_v [LANES];
    int w_v   [LANES];

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LANES*ACT_W-1:0] pack_act();
        logic [LANES*ACT_W-1:0] a;
        for (int i = 0; i < LANES; i++) a[i*ACT_W +: ACT_W] = ACT_W'(act_v[i]);
        return a;
    endfunction

    task automatic drive_bit(input int b);
        for (int i = 0; i < LANES; i++) weight_bit[i] = 1'(w_v[i] >> b);
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    task automatic run_op(input int gap_max, input int ready_hold, input bit poke);
        logic [RW-1:0] held;
        activation = pack_act();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = WB - 1; b >= 0; b--) begin
            if (poke && b == 4) begin
                start = 1'b1;
                activation = ~pack_act();
            end
            drive_bit(b);
            start = 1'b0;
            if (b > 0) repeat ($urandom_range(gap_max, 0)) tick();
        end
        check("ov_latency_u", RW'(ov_u), RW'(1));
        check("ov_latency_s", RW'(ov_s), RW'(1));
        held = res_u;
        for (int c = 0; c < ready_hold; c++) begin
            if (poke && c == 0) begin
                start = 1'b1;
                activation = ~pack_act();
            end
            tick();
            start = 1'b0;
            check("res_hold", res_u, held);
            check("ov_hold", RW'(ov_u), RW'(1));
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check("hs_idle_u", RW'(busy_u), RW'(0));
        check("hs_ov_u", RW'(ov_u), RW'(0));
        check("hs_res_u", res_u, held);
    endtask

    task automatic zero_vecs;
        for (int i = 0; i < LANES; i++) begin
            act_v[i] = 0;
            w_v[i]   = 0;
        end
    endtask

    initial begin
        zero_vecs();
        repeat (3) tick();
        check("rst_res_u", res_u, '0);
        check("rst_busy_u", RW'(busy_u), RW'(0));
        check("rst_bc_s", RW'(bc_s), RW'(0));
        rst_n = 1'b1;
        repeat (2) tick();

        // Unsigned basic: 3*5 and 0xFFFF*0xFF
        zero_vecs();
        act_v[0] = 16'h0003; w_v[0] = 8'h05;
        act_v[1] = 16'hFFFF; w_v[1] = 8'hFF;
        run_op(0, 0, 1'b0);
        check("u_l0_3x5", RW'(res_u[23:0]), RW'(24'h00000F));
        check("s_l0_3x5", RW'(res_s[23:0]), RW'(24'h00000F));
        check("u_l1_ffff_ff", RW'(res_u[47:24]), RW'(24'hFEFF01));
        check("s_l1_ffff_m1", RW'(res_s[47:24]), RW'(24'hFF0001));

        // Signed extremes with gapped bits and backpressure
        zero_vecs();
        act_v[0] = 16'h0003; w_v[0] = 8'hFF;
        act_v[1] = 16'hFFFF; w_v[1] = 8'h80;
        run_op(5, 10, 1'b0);
        check("s_l0_3xm1", RW'(res_s[23:0]), RW'(24'hFFFFFD));
        check("s_l1_ffff_m128", RW'(res_s[47:24]), RW'(24'h800080));
        check("u_l0_3x255", RW'(res_u[23:0]), RW'(24'h0002FD));
        check("u_l1_ffff_128", RW'(res_u[47:24]), RW'(24'h7FFF80));

        // Start pulses during RUN and DONE are ignored
        zero_vecs();
        act_v[0] = 16'h1234; w_v[0] = 8'h5A;
        run_op(2, 3, 1'b1);
        check("poke_u", RW'(res_u[23:0]), RW'(24'h066648));
        check("poke_s", RW'(res_s[23:0]), RW'(24'h066648));

        // Clear after three bits
        activation = pack_act();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = WB - 1; b > WB - 4; b--) drive_bit(b);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_busy", RW'(busy_u), RW'(0));
        check("clr_bc", RW'(bc_s), RW'(0));
        check("clr_res_u", res_u, '0);
        check("clr_res_s", res_s, '0);

        // Asynchronous reset after five bits
        activation = pack_act();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = WB - 1; b > WB - 6; b--) drive_bit(b);
        #2 rst_n = 1'b0;
        #1;
        check("arst_res_u", res_u, '0);
        check("arst_res_s", res_s, '0);
        check("arst_busy", RW'(busy_s), RW'(0));
        check("arst_bc", RW'(bc_u), RW'(0));
        check("arst_ov", RW'(ov_u), RW'(0));
        tick();
        rst_n = 1'b1;
        repeat (2) tick();
        check("post_rst_idle", RW'(busy_u), RW'(0));

        // All lanes: act_i = i, weight_i = i
        for (int i = 0; i < LANES; i++) begin
            act_v[i] = i;
            w_v[i]   = i;
        end
        run_op(1, 2, 1'b0);
        for (int i = 0; i < LANES; i++) begin
            check("lane_sq_u", RW'(res_u[i*ACC_W +: ACC_W]), RW'(i * i));
            check("lane_sq_s", RW'(res_s[i*ACC_W +: ACC_W]), RW'(i * i));
        end

        repeat (2) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/and_mult_serial_array.md
AND_MULT_SERIAL_ARRAY -- requirements
Module: and_mult_serial_array

Interface
REQ-001 SHALL have parameter LANES, default 32: number of independent multiplier lanes.
REQ-002 SHALL have parameter ACT_W, default 16: activation width per lane, unsigned.
REQ-003 SHALL have parameter WGT_BITS, default 8: weight bits per lane, streamed MSB first.
REQ-004 SHALL have parameter SIGNED_W, default 0: 1 = weight is two's complement, 0 = weight is unsigned.
REQ-005 SHALL use derived ACC_W = ACT_W+WGT_BITS as the per-lane result width.
REQ-006 SHALL have port clk, input, 1: sole clock; all state updates on the rising edge.
REQ-007 SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-008 SHALL have port start, input, 1: begin an operation; latches activations.
REQ-009 SHALL have port activation, input, LANES*ACT_W: lane i at bits [i*ACT_W +: ACT_W].
REQ-010 SHALL have port weight_bit, input, LANES: current weight digit, one bit per lane.
REQ-011 SHALL have port bit_valid, input, 1: weight_bit is presented this cycle.
REQ-012 SHALL have port clear, input, 1: synchronous abort.
REQ-013 SHALL have port busy, output, 1: high in RUN and DONE.
REQ-014 SHALL have port bit_count, output, clog2(WGT_BITS+1): weight bits accepted so far.
REQ-015 SHALL have port out_valid, output, 1: result is valid.
REQ-016 SHALL have port out_ready, input, 1: consumer accepts result.
REQ-017 SHALL have port result, output, LANES*ACC_W: lane i at bits [i*ACC_W +: ACC_W].

Function
REQ-018 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-019 SHALL, in IDLE with start=1: latch all activations, clear all accumulators and bit_count to 0, and go to RUN on the next edge.
REQ-020 SHALL ignore start in RUN and DONE; the latched activations stay unchanged.
REQ-021 SHALL, in RUN with bit_valid=1, update each lane: acc = (acc<<1) + (weight_bit[i] ? act_i : 0), truncated to ACC_W; bit_count increments.
REQ-022 SHALL, if SIGNED_W=1, subtract act_i instead of adding it on the first accepted bit (bit_count=0, the MSB); acc is then a two's-complement ACC_W value.
REQ-023 SHALL, in RUN with bit_valid=0, hold all state; gaps between bits are unbounded.
REQ-024 SHALL move to DONE on the edge that accepts bit WGT_BITS; out_valid rises the following cycle, and the latency from the last bit to out_valid is 1 cycle.
REQ-025 SHALL hold result stable while out_valid=1; result reflects the accumulators at all times.
REQ-026 SHALL complete the handshake when out_valid & out_ready are both high at a rising edge; then go to IDLE and drop out_valid.
REQ-027 SHALL allow start in the same cycle as the handshake edge and ignore it; a new start is accepted only in IDLE.
REQ-028 SHALL ignore bit_valid in IDLE and DONE.
REQ-029 SHALL, when clear=1 in any state, go to IDLE, zero the accumulators and bit_count, and drop out_valid; clear takes priority over start, bit_valid and out_ready.
REQ-030 SHALL produce no overflow in the accumulator: ACC_W bits hold the full product for both weight modes.
REQ-031 SHALL give all lanes identical timing: one shared FSM and counter, with per-lane datapaths only.

Reset
REQ-032 SHALL, on rst_n=0 (asynchronous), enter IDLE immediately.
REQ-033 SHALL, during reset, force busy=0, out_valid=0, bit_count=0, result=0 and activation registers=0.
REQ-034 SHALL, on reset asserted mid-RUN or in DONE, discard the partial result; after release the block waits in IDLE for start.
REQ-035 SHALL take the first state change after rst_n deasserts on the first rising edge.

Verification
REQ-036 SHALL verify unsigned mode (SIGNED_W=0): lane0 act=0x0003, weight 0x05 streamed as 0,0,0,0,0,1,0,1 -> result lane0 = 0x00000F, and out_valid one cycle after the 8th bit.
REQ-037 SHALL verify signed mode (SIGNED_W=1): act=0x0003, weight 0xFF -> result 0xFFFFFD (-3); act=0xFFFF, weight 0x80 -> 0x800080 (-8388480).
REQ-038 SHALL verify gapped bits and backpressure: bit_valid randomly low for 0-5 cycles and out_ready held low 10 cycles -> result unchanged while out_valid=1, with a single handshake.
REQ-039 SHALL verify start ignored while busy: start pulses in RUN and DONE -> activations unchanged, result correct, and a new operation begins only from IDLE.
REQ-040 SHALL verify clear and reset mid-operation: clear after 3 bits -> IDLE with acc=0; rst_n low after 5 bits -> all outputs 0 asynchronously, and the next full operation is correct.
REQ-041 SHALL verify all lanes: LANES=32, act_i=i, weight_i=i -> result_i = i*i for every lane.
